// File: rtl/wb_port_scheduler_if.sv
// wb_port_scheduler_if: ALU writeback, load issue/return, hazard-check and
// register-file write bundle for the write-port scheduler.
interface wb_port_scheduler_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int CW = $clog2(DEPTH + 1);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_issue_addr;
    logic              ld_ret_valid;
    logic [ADDR_W-1:0] ld_ret_addr;
    logic [DATA_W-1:0] ld_ret_data;
    logic [ADDR_W-1:0] chk_rs;
    logic [ADDR_W-1:0] chk_rt;
    logic              hazard;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CW-1:0]     fifo_count;
    logic              issue_err;
    modport master (
        output alu_valid, alu_addr, alu_data, ld_issue, ld_issue_addr,
               ld_ret_valid, ld_ret_addr, ld_ret_data, chk_rs, chk_rt,
        input  alu_ready, hazard, wr_en, wr_addr, wr_data, fifo_count, issue_err
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_issue, ld_issue_addr,
               ld_ret_valid, ld_ret_addr, ld_ret_data, chk_rs, chk_rt,
        output alu_ready, hazard, wr_en, wr_addr, wr_data, fifo_count, issue_err
    );
endinterface

// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler: arbitrates the register-file write port (load returns first, ALU via FIFO)
// and tracks outstanding loads for hazard detection. Define WB_BYPASS_EN for the empty-FIFO ALU bypass.
module wb_port_scheduler #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic clock,
    input logic reset,
    wb_port_scheduler_if.slave bus
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int NREG = 1 << ADDR_W;

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_d [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DATA_W-1:0] mem_data_d [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, off;
    logic [CW-1:0]     count_q, count_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wr_en_q, wr_en_d, issue_err_q, issue_err_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              empty, push, pop, bypass, fifo_hit;

    assign empty         = count_q == '0;
    assign bus.alu_ready = count_q != CW'(DEPTH);
`ifdef WB_BYPASS_EN
    assign bypass = empty & ~bus.ld_ret_valid & bus.alu_valid;
`else
    assign bypass = 1'b0;
`endif
    assign push = bus.alu_valid & bus.alu_ready & ~bypass;
    assign pop  = ~bus.ld_ret_valid & ~empty;

    always_comb begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (bus.ld_ret_valid) begin
            wr_addr_d = bus.ld_ret_addr;
            wr_data_d = bus.ld_ret_data;
        end else if (!empty) begin
            wr_addr_d = mem_addr_q[rd_ptr_q];
            wr_data_d = mem_data_q[rd_ptr_q];
        end else if (bypass) begin
            wr_addr_d = bus.alu_addr;
            wr_data_d = bus.alu_data;
        end else begin
            wr_en_d = 1'b0;
        end
        // Writes to r0 still consume their slot but never reach the register file.
        if (wr_addr_d == '0) wr_en_d = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (push) begin
            mem_addr_d[wr_ptr_q] = bus.alu_addr;
            mem_data_d[wr_ptr_q] = bus.alu_data;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        busy_d   = busy_q;
        if (bus.ld_ret_valid) busy_d[bus.ld_ret_addr] = 1'b0;
        if (bus.ld_issue && bus.ld_issue_addr != '0) busy_d[bus.ld_issue_addr] = 1'b1;
        issue_err_d = bus.ld_issue & busy_q[bus.ld_issue_addr];
    end

    // Queued ALU results are not yet in the register file, so they count as pending writes.
    always_comb begin
        fifo_hit = 1'b0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (CW'(off) < count_q &&
                ((bus.chk_rs != '0 && mem_addr_q[i] == bus.chk_rs) ||
                 (bus.chk_rt != '0 && mem_addr_q[i] == bus.chk_rt)))
                fifo_hit = 1'b1;
        end
    end

    assign bus.hazard     = busy_q[bus.chk_rs] | busy_q[bus.chk_rt] | fifo_hit;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.fifo_count = count_q;
    assign bus.issue_err  = issue_err_q;

    always_ff @(posedge clock) begin
        mem_addr_q <= mem_addr_d;
        mem_data_q <= mem_data_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            issue_err_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            issue_err_q <= issue_err_d;
        end
    end
endmodule

// File: tb/tb_wb_port_scheduler.sv
// tb_wb_port_scheduler: directed scenarios plus random traffic against a queue-based
// reference model of the write-port scheduler.
module tb_wb_port_scheduler;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_on = 1'b0;
    bit   hold = 1'b0;
    bit   acc;

    wb_port_scheduler_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    wb_port_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              m_q[$];
    logic [31:0]       m_busy;
    logic              m_en, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: one step per clock edge, from the rules for write selection and scoreboard.
    task automatic model_step();
        ent_t e;
        bit   byp;
        int   pre;
        if (reset) begin
            m_q.delete();
            m_busy = '0;
            m_en   = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_err  = 1'b0;
            return;
        end
        pre = m_q.size();
`ifdef WB_BYPASS_EN
        byp = pre == 0 && !bus.ld_ret_valid && bus.alu_valid;
`else
        byp = 1'b0;
`endif
        m_err = bus.ld_issue && m_busy[bus.ld_issue_addr];
        m_en  = 1'b1;
        if (bus.ld_ret_valid) begin
            m_addr = bus.ld_ret_addr;
            m_data = bus.ld_ret_data;
        end else if (pre > 0) begin
            e = m_q.pop_front();
            m_addr = e.a;
            m_data = e.d;
        end else if (byp) begin
            m_addr = bus.alu_addr;
            m_data = bus.alu_data;
        end else begin
            m_en = 1'b0;
        end
        if (m_addr == 0) m_en = 1'b0;
        if (bus.alu_valid && pre != DEPTH && !byp) m_q.push_back({bus.alu_addr, bus.alu_data});
        if (bus.ld_ret_valid) m_busy[bus.ld_ret_addr] = 1'b0;
        if (bus.ld_issue && bus.ld_issue_addr != 0) m_busy[bus.ld_issue_addr] = 1'b1;
    endtask

    function automatic bit m_hazard();
        bit h = m_busy[bus.chk_rs] | m_busy[bus.chk_rt];
        foreach (m_q[i])
            if ((bus.chk_rs != 0 && m_q[i].a == bus.chk_rs) || (bus.chk_rt != 0 && m_q[i].a == bus.chk_rt))
                h = 1'b1;
        return h;
    endfunction

    always @(negedge clock) begin
        if (chk_on) begin
            chk("wr_en", bus.wr_en, m_en);
            chk("wr_addr", bus.wr_addr, m_addr);
            chk("wr_data", bus.wr_data, m_data);
            chk("fifo_count", bus.fifo_count, m_q.size());
            chk("alu_ready", bus.alu_ready, m_q.size() != DEPTH);
            chk("hazard", bus.hazard, m_hazard());
            chk("issue_err", bus.issue_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        #2;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.ld_issue = 1'b0; bus.ld_issue_addr = '0;
        bus.ld_ret_valid = 1'b0; bus.ld_ret_addr = '0; bus.ld_ret_data = '0;
        bus.chk_rs = '0; bus.chk_rt = '0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_ready", bus.alu_ready, 1);
        chk("rst_wr_en", bus.wr_en, 0);
        reset = 1'b0;

        // ALU only
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd8; bus.alu_data = 32'h12345678;
        tick();
        bus.alu_valid = 1'b0;
`ifdef WB_BYPASS_EN
        chk("alu_n1_en", bus.wr_en, 1);
        chk("alu_n1_addr", bus.wr_addr, 8);
        chk("alu_n1_data", bus.wr_data, 32'h12345678);
        tick();
`else
        chk("alu_n1_en", bus.wr_en, 0);
        tick();
        chk("alu_n2_en", bus.wr_en, 1);
        chk("alu_n2_addr", bus.wr_addr, 8);
        chk("alu_n2_data", bus.wr_data, 32'h12345678);
`endif

        // Load-return priority over queued ALU writes
        bus.ld_ret_valid = 1'b1; bus.ld_ret_addr = 5'd9; bus.ld_ret_data = 32'hDEADBEEF;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h33;
        tick();
        chk("pri_w1", bus.wr_addr, 9);
        bus.alu_addr = 5'd4; bus.alu_data = 32'h44;
        tick();
        chk("pri_w2", bus.wr_addr, 9);
        chk("pri_peak", bus.fifo_count, 2);
        bus.alu_valid = 1'b0;
        tick();
        chk("pri_w3", bus.wr_addr, 9);
        chk("pri_w3_data", bus.wr_data, 32'hDEADBEEF);
        bus.ld_ret_valid = 1'b0;
        tick();
        chk("pri_a3", bus.wr_addr, 3);
        tick();
        chk("pri_a4", bus.wr_addr, 4);
        chk("pri_empty", bus.fifo_count, 0);

        // Full FIFO with a held fifth request
        bus.ld_ret_valid = 1'b1; bus.ld_ret_addr = 5'd10;
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = 5'(11 + i); bus.alu_data = 32'(100 + i);
            tick();
        end
        chk("full_count", bus.fifo_count, 4);
        chk("full_ready", bus.alu_ready, 0);
        bus.alu_addr = 5'd15; bus.alu_data = 32'hF5;
        tick();
        tick();
        chk("full_hold_count", bus.fifo_count, 4);
        bus.ld_ret_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            acc = bus.alu_valid && bus.alu_ready;
            tick();
            if (acc) bus.alu_valid = 1'b0;
            chk($sformatf("full_w%0d", i), bus.wr_addr, 11 + i);
            chk($sformatf("full_en%0d", i), bus.wr_en, 1);
        end
        chk("full_last_data", bus.wr_data, 32'hF5);
        chk("full_drained", bus.fifo_count, 0);

        // Scoreboard
        idle();
        bus.ld_issue = 1'b1; bus.ld_issue_addr = 5'd5;
        tick();
        bus.ld_issue = 1'b0; bus.chk_rs = 5'd5;
        #1 chk("sb_haz", bus.hazard, 1);
        bus.ld_issue = 1'b1;
        tick();
        bus.ld_issue = 1'b0;
        chk("sb_err", bus.issue_err, 1);
        tick();
        chk("sb_err_clr", bus.issue_err, 0);
        chk("sb_haz_hold", bus.hazard, 1);
        bus.ld_ret_valid = 1'b1; bus.ld_ret_addr = 5'd5; bus.ld_ret_data = 32'h55;
        tick();
        bus.ld_ret_valid = 1'b0;
        #1 chk("sb_haz_clr", bus.hazard, 0);
        chk("sb_ret_addr", bus.wr_addr, 5);

        // Hazard from a queued ALU entry
        bus.chk_rs = '0;
        bus.ld_ret_valid = 1'b1; bus.ld_ret_addr = 5'd1;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd6; bus.alu_data = 32'h66;
        tick();
        bus.alu_valid = 1'b0; bus.chk_rt = 5'd6;
        #1 chk("fifo_haz", bus.hazard, 1);
        bus.ld_ret_valid = 1'b0;
        tick();
        #1 chk("fifo_haz_clr", bus.hazard, 0);

        // Zero register
        idle();
        bus.alu_valid = 1'b1; bus.alu_addr = '0; bus.alu_data = 32'hFFFFFFFF;
        tick();
        bus.alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("zero_en%0d", i), bus.wr_en, 0);
            tick();
        end
        bus.ld_issue = 1'b1; bus.ld_issue_addr = '0;
        tick();
        bus.ld_issue = 1'b0;
        #1 chk("zero_haz", bus.hazard, 0);

        // Reset mid-operation
        bus.ld_ret_valid = 1'b1; bus.ld_ret_addr = 5'd2;
        bus.ld_issue = 1'b1; bus.ld_issue_addr = 5'd7;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = 5'(20 + i); bus.alu_data = 32'(i);
            tick();
            bus.ld_issue = 1'b0;
        end
        chk("mid_count", bus.fifo_count, 3);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.chk_rs = 5'd7;
        #1;
        chk("mid_rst_count", bus.fifo_count, 0);
        chk("mid_rst_en", bus.wr_en, 0);
        chk("mid_rst_haz", bus.hazard, 0);
        chk("mid_rst_ready", bus.alu_ready, 1);

        // Random traffic
        hold = 1'b0;
        repeat (3000) begin
            reset = $urandom_range(0, 249) == 0;
            if (!hold) begin
                bus.alu_valid = $urandom_range(0, 99) < 60;
                bus.alu_addr  = 5'($urandom_range(0, 7));
                bus.alu_data  = $urandom;
            end
            bus.ld_ret_valid  = $urandom_range(0, 99) < 45;
            bus.ld_ret_addr   = 5'($urandom_range(0, 7));
            bus.ld_ret_data   = $urandom;
            bus.ld_issue      = $urandom_range(0, 99) < 30;
            bus.ld_issue_addr = 5'($urandom_range(0, 7));
            bus.chk_rs        = 5'($urandom_range(0, 7));
            bus.chk_rt        = 5'($urandom_range(0, 7));
            hold = bus.alu_valid && m_q.size() == DEPTH && !reset;
            tick();
        end
        reset = 1'b0;
        idle();
        tick();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
